// File: rtl/mips_pkg.sv
// Shared encodings for the reduced MIPS decode path: opcodes, function codes,
// ALU operation codes and the internal control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam int unsigned REG_RA    = 31;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_NOR    = 4'd5,
    ALU_SLT    = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_LUI    = 4'd10,
    ALU_PASS_A = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2,
    DST_RA   = 2'd3
  } dest_sel_e;

  typedef enum logic [1:0] {
    IMM_SIGN  = 2'd0,
    IMM_ZERO  = 2'd1,
    IMM_UPPER = 2'd2
  } imm_kind_e;

  typedef struct packed {
    alu_op_e   alu_op;
    logic      alu_src_imm;
    logic      mem_read;
    logic      mem_write;
    logic      mem_to_reg;
    logic      reg_write;
    dest_sel_e dest_sel;
    imm_kind_e imm_kind;
    logic      rt_is_src;  // rt feeds the datapath (matters for load-use)
    logic      jump;       // J/JAL absolute target
    logic      jump_reg;   // JR/JALR register target
    logic      link;       // operand A replaced by PC+4
    logic      halt;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_control_decoder.sv
// Purely combinational opcode/funct decode into the control bundle.
// Unknown encodings leave the bundle all-zero (a NOP).
module control_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [5:0] op;
  logic [5:0] fn;

  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];

  // Map the instruction word onto control signals.
  always_comb begin
    ctrl_o = '0;
    if (instr_i == HALT_WORD) begin
      ctrl_o.halt = 1'b1;
    end else begin
      case (op)
        OP_RTYPE: begin
          case (fn)
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT,
            FN_SLL, FN_SRL, FN_SRA: begin
              ctrl_o.dest_sel  = DST_RD;
              ctrl_o.reg_write = 1'b1;
              ctrl_o.rt_is_src = 1'b1;
              case (fn)
                FN_SUBU: ctrl_o.alu_op = ALU_SUB;
                FN_AND:  ctrl_o.alu_op = ALU_AND;
                FN_OR:   ctrl_o.alu_op = ALU_OR;
                FN_XOR:  ctrl_o.alu_op = ALU_XOR;
                FN_NOR:  ctrl_o.alu_op = ALU_NOR;
                FN_SLT:  ctrl_o.alu_op = ALU_SLT;
                FN_SLL:  ctrl_o.alu_op = ALU_SLL;
                FN_SRL:  ctrl_o.alu_op = ALU_SRL;
                FN_SRA:  ctrl_o.alu_op = ALU_SRA;
                default: ctrl_o.alu_op = ALU_ADD;
              endcase
            end
            FN_JR: begin
              ctrl_o.dest_sel = DST_RD;
              ctrl_o.jump_reg = 1'b1;
            end
            FN_JALR: begin
              ctrl_o.dest_sel  = DST_RD;
              ctrl_o.jump_reg  = 1'b1;
              ctrl_o.link      = 1'b1;
              ctrl_o.reg_write = 1'b1;
              ctrl_o.alu_op    = ALU_PASS_A;
            end
            default: ctrl_o = '0;
          endcase
        end
        OP_J: ctrl_o.jump = 1'b1;
        OP_JAL: begin
          ctrl_o.jump      = 1'b1;
          ctrl_o.link      = 1'b1;
          ctrl_o.dest_sel  = DST_RA;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALU_PASS_A;
        end
        OP_BEQ, OP_BNE: begin
          ctrl_o.alu_op    = ALU_SUB;
          ctrl_o.dest_sel  = DST_RT;
          ctrl_o.rt_is_src = 1'b1;
        end
        OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          ctrl_o.dest_sel    = DST_RT;
          ctrl_o.alu_src_imm = 1'b1;
          ctrl_o.reg_write   = 1'b1;
          case (op)
            OP_SLTI: ctrl_o.alu_op = ALU_SLT;
            OP_ANDI: begin ctrl_o.alu_op = ALU_AND; ctrl_o.imm_kind = IMM_ZERO;  end
            OP_ORI:  begin ctrl_o.alu_op = ALU_OR;  ctrl_o.imm_kind = IMM_ZERO;  end
            OP_XORI: begin ctrl_o.alu_op = ALU_XOR; ctrl_o.imm_kind = IMM_ZERO;  end
            OP_LUI:  begin ctrl_o.alu_op = ALU_LUI; ctrl_o.imm_kind = IMM_UPPER; end
            default: ctrl_o.alu_op = ALU_ADD;
          endcase
        end
        OP_LW: begin
          ctrl_o.dest_sel    = DST_RT;
          ctrl_o.alu_src_imm = 1'b1;
          ctrl_o.mem_read    = 1'b1;
          ctrl_o.mem_to_reg  = 1'b1;
          ctrl_o.reg_write   = 1'b1;
        end
        OP_SW: begin
          ctrl_o.dest_sel    = DST_RT;
          ctrl_o.alu_src_imm = 1'b1;
          ctrl_o.mem_write   = 1'b1;
          ctrl_o.rt_is_src   = 1'b1;
        end
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS-reduced ID stage: operand fetch with WB bypass, immediate extension,
// load-use stall, jump resolution, sticky HALT and the ID/EX latch.
module decode_stage
  import mips_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int N_REGS   = 32,
  parameter int _NB_ADDR = $clog2(N_REGS),
  parameter int NB_ALUOP = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic [NB_DATA-1:0]  i_instruction,
  input  logic [NB_DATA-1:0]  i_pc_plus4,
  output logic [_NB_ADDR-1:0] o_read_addr_rs,
  output logic [_NB_ADDR-1:0] o_read_addr_rt,
  input  logic [NB_DATA-1:0]  i_data_rs,
  input  logic [NB_DATA-1:0]  i_data_rt,
  input  logic                i_wb_write_enable,
  input  logic [_NB_ADDR-1:0] i_wb_write_addr,
  input  logic [NB_DATA-1:0]  i_wb_data,
  input  logic                i_ex_mem_read,
  input  logic [_NB_ADDR-1:0] i_ex_rt_addr,
  output logic                o_stall,
  output logic                o_jump,
  output logic [NB_DATA-1:0]  o_jump_target,
  output logic                o_halted,
  output logic                o_valid,
  output logic [NB_DATA-1:0]  o_rs_data,
  output logic [NB_DATA-1:0]  o_rt_data,
  output logic [NB_DATA-1:0]  o_imm,
  output logic [4:0]          o_shamt,
  output logic [_NB_ADDR-1:0] o_rs_addr,
  output logic [_NB_ADDR-1:0] o_rt_addr,
  output logic [_NB_ADDR-1:0] o_dest_addr,
  output logic [NB_ALUOP-1:0] o_alu_op,
  output logic                o_alu_src_imm,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_mem_to_reg,
  output logic                o_reg_write
);

  ctrl_t               ctrl;
  logic [_NB_ADDR-1:0] rs_addr, rt_addr, rd_addr, dest_addr;
  logic [NB_DATA-1:0]  rs_val, rt_val, imm_ext;
  logic                hazard, bubble;

  logic                halted_q, halted_d;
  logic                valid_q, valid_d;
  logic [NB_DATA-1:0]  rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [4:0]          shamt_q, shamt_d;
  logic [_NB_ADDR-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, dest_q, dest_d;
  logic [NB_ALUOP-1:0] alu_op_q, alu_op_d;
  logic                src_imm_q, src_imm_d, mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic                reg_write_q, reg_write_d;

  control_decoder u_control_decoder (
    .instr_i (i_instruction[31:0]),
    .ctrl_o  (ctrl)
  );

  assign rs_addr        = i_instruction[21 +: _NB_ADDR];
  assign rt_addr        = i_instruction[16 +: _NB_ADDR];
  assign rd_addr        = i_instruction[11 +: _NB_ADDR];
  assign o_read_addr_rs = rs_addr;
  assign o_read_addr_rt = rt_addr;

  // Operand selection with same-cycle WB bypass, immediate and destination.
  always_comb begin
    rs_val = i_data_rs;
    rt_val = i_data_rt;
    if (i_wb_write_enable && (i_wb_write_addr == rs_addr) && (rs_addr != '0))
      rs_val = i_wb_data;
    if (i_wb_write_enable && (i_wb_write_addr == rt_addr) && (rt_addr != '0))
      rt_val = i_wb_data;

    case (ctrl.imm_kind)
      IMM_ZERO:  imm_ext = {{(NB_DATA-16){1'b0}}, i_instruction[15:0]};
      IMM_UPPER: imm_ext = {i_instruction[15:0], {(NB_DATA-16){1'b0}}};
      default:   imm_ext = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};
    endcase

    case (ctrl.dest_sel)
      DST_RD:  dest_addr = rd_addr;
      DST_RT:  dest_addr = rt_addr;
      DST_RA:  dest_addr = _NB_ADDR'(REG_RA);
      default: dest_addr = '0;
    endcase
  end

  // Load-use hazard, stall/jump outputs and the bubble decision.
  always_comb begin
    hazard = i_valid && i_ex_mem_read && (i_ex_rt_addr != '0) &&
             ((i_ex_rt_addr == rs_addr) || (ctrl.rt_is_src && (i_ex_rt_addr == rt_addr)));
    o_stall = i_enable && (hazard || halted_q);
    o_jump  = i_enable && i_valid && !halted_q && !o_stall && (ctrl.jump || ctrl.jump_reg);
    o_jump_target = ctrl.jump_reg ? rs_val
                                  : {i_pc_plus4[31:28], i_instruction[25:0], 2'b00};
    bubble   = !i_valid || halted_q || hazard || ctrl.halt;
    halted_d = halted_q || (i_valid && ctrl.halt && !hazard);
  end

  // Next contents of the ID/EX latch; a bubble clears every field.
  always_comb begin
    valid_d      = 1'b0;
    rs_data_d    = '0;
    rt_data_d    = '0;
    imm_d        = '0;
    shamt_d      = '0;
    rs_addr_d    = '0;
    rt_addr_d    = '0;
    dest_d       = '0;
    alu_op_d     = '0;
    src_imm_d    = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    if (!bubble) begin
      valid_d      = 1'b1;
      rs_data_d    = ctrl.link ? i_pc_plus4 : rs_val;
      rt_data_d    = rt_val;
      imm_d        = imm_ext;
      shamt_d      = i_instruction[10:6];
      rs_addr_d    = rs_addr;
      rt_addr_d    = rt_addr;
      dest_d       = dest_addr;
      alu_op_d     = NB_ALUOP'(ctrl.alu_op);
      src_imm_d    = ctrl.alu_src_imm;
      mem_read_d   = ctrl.mem_read;
      mem_write_d  = ctrl.mem_write;
      mem_to_reg_d = ctrl.mem_to_reg;
      reg_write_d  = ctrl.reg_write && (dest_addr != '0);
    end
  end

  // ID/EX latch and sticky halt flag; reset wins over enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      halted_q     <= 1'b0;
      valid_q      <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      dest_q       <= '0;
      alu_op_q     <= '0;
      src_imm_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
    end else if (i_enable) begin
      halted_q     <= halted_d;
      valid_q      <= valid_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      shamt_q      <= shamt_d;
      rs_addr_q    <= rs_addr_d;
      rt_addr_q    <= rt_addr_d;
      dest_q       <= dest_d;
      alu_op_q     <= alu_op_d;
      src_imm_q    <= src_imm_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
    end
  end

  assign o_halted      = halted_q;
  assign o_valid       = valid_q;
  assign o_rs_data     = rs_data_q;
  assign o_rt_data     = rt_data_q;
  assign o_imm         = imm_q;
  assign o_shamt       = shamt_q;
  assign o_rs_addr     = rs_addr_q;
  assign o_rt_addr     = rt_addr_q;
  assign o_dest_addr   = dest_q;
  assign o_alu_op      = alu_op_q;
  assign o_alu_src_imm = src_imm_q;
  assign o_mem_read    = mem_read_q;
  assign o_mem_write   = mem_write_q;
  assign o_mem_to_reg  = mem_to_reg_q;
  assign o_reg_write   = reg_write_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic compared against an instruction-level reference model.
module tb_decode_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, valid;
  logic [31:0] instr, pc4, d_rs, d_rt, wb_data;
  logic        wb_we, ex_mr;
  logic [4:0]  wb_addr, ex_rt;
  logic [4:0]  ra_rs, ra_rt;
  logic        stall, jump, halted, v_o;
  logic [31:0] jtgt, rs_o, rt_o, imm_o;
  logic [4:0]  shamt_o, rsa_o, rta_o, dst_o;
  logic [3:0]  alu_o;
  logic        srci_o, mr_o, mw_o, m2r_o, rw_o;

  always #5 clk = ~clk;

  decode_stage #(.NB_DATA(32), .N_REGS(32), .NB_ALUOP(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_valid(valid),
    .i_instruction(instr), .i_pc_plus4(pc4),
    .o_read_addr_rs(ra_rs), .o_read_addr_rt(ra_rt),
    .i_data_rs(d_rs), .i_data_rt(d_rt),
    .i_wb_write_enable(wb_we), .i_wb_write_addr(wb_addr), .i_wb_data(wb_data),
    .i_ex_mem_read(ex_mr), .i_ex_rt_addr(ex_rt),
    .o_stall(stall), .o_jump(jump), .o_jump_target(jtgt), .o_halted(halted),
    .o_valid(v_o), .o_rs_data(rs_o), .o_rt_data(rt_o), .o_imm(imm_o),
    .o_shamt(shamt_o), .o_rs_addr(rsa_o), .o_rt_addr(rta_o), .o_dest_addr(dst_o),
    .o_alu_op(alu_o), .o_alu_src_imm(srci_o), .o_mem_read(mr_o),
    .o_mem_write(mw_o), .o_mem_to_reg(m2r_o), .o_reg_write(rw_o)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt, rs_addr, rt_addr, dest;
    logic [3:0]  alu_op;
    logic        src_imm, mr, mw, m2r, rw;
  } idex_t;

  idex_t       exp_q;
  logic        exp_halt;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Does the instruction read rt as an operand?
  function automatic logic uses_rt(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (ins == 32'hFFFF_FFFF) return 1'b0;
    if (op == 6'd0)
      return fn inside {6'd0, 6'd2, 6'd3, 6'd33, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42};
    return op inside {6'd4, 6'd5, 6'd43};
  endfunction

  // What the ID/EX latch should hold for a non-bubble instruction.
  function automatic idex_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] rsv, input logic [31:0] rtv);
    idex_t e;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    e = '0;
    e.valid   = 1'b1;
    e.rs_data = rsv;
    e.rt_data = rtv;
    e.imm     = {{16{ins[15]}}, ins[15:0]};
    e.shamt   = ins[10:6];
    e.rs_addr = rs;
    e.rt_addr = rt;
    case (op)
      6'd0: begin
        e.dest = rd;
        e.rw   = 1'b1;
        case (fn)
          6'd33: e.alu_op = ALU_ADD;
          6'd35: e.alu_op = ALU_SUB;
          6'd36: e.alu_op = ALU_AND;
          6'd37: e.alu_op = ALU_OR;
          6'd38: e.alu_op = ALU_XOR;
          6'd39: e.alu_op = ALU_NOR;
          6'd42: e.alu_op = ALU_SLT;
          6'd0:  e.alu_op = ALU_SLL;
          6'd2:  e.alu_op = ALU_SRL;
          6'd3:  e.alu_op = ALU_SRA;
          6'd8:  e.rw = 1'b0;
          6'd9:  begin e.alu_op = ALU_PASS_A; e.rs_data = pc; end
          default: begin e.dest = 5'd0; e.rw = 1'b0; end
        endcase
      end
      6'd2:  ;
      6'd3:  begin e.dest = 5'd31; e.rw = 1'b1; e.alu_op = ALU_PASS_A; e.rs_data = pc; end
      6'd4, 6'd5: begin e.dest = rt; e.alu_op = ALU_SUB; end
      6'd9:  begin e.dest = rt; e.rw = 1; e.src_imm = 1; e.alu_op = ALU_ADD; end
      6'd10: begin e.dest = rt; e.rw = 1; e.src_imm = 1; e.alu_op = ALU_SLT; end
      6'd12: begin e.dest = rt; e.rw = 1; e.src_imm = 1; e.alu_op = ALU_AND; e.imm = {16'h0, ins[15:0]}; end
      6'd13: begin e.dest = rt; e.rw = 1; e.src_imm = 1; e.alu_op = ALU_OR;  e.imm = {16'h0, ins[15:0]}; end
      6'd14: begin e.dest = rt; e.rw = 1; e.src_imm = 1; e.alu_op = ALU_XOR; e.imm = {16'h0, ins[15:0]}; end
      6'd15: begin e.dest = rt; e.rw = 1; e.src_imm = 1; e.alu_op = ALU_LUI; e.imm = {ins[15:0], 16'h0}; end
      6'd35: begin e.dest = rt; e.rw = 1; e.src_imm = 1; e.mr = 1; e.m2r = 1; e.alu_op = ALU_ADD; end
      6'd43: begin e.dest = rt; e.src_imm = 1; e.mw = 1; e.alu_op = ALU_ADD; end
      default: ;
    endcase
    if (e.dest == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  task automatic check_regs();
    check_val("halted",     {31'd0, halted},  {31'd0, exp_halt});
    check_val("valid",      {31'd0, v_o},     {31'd0, exp_q.valid});
    check_val("rs_data",    rs_o,             exp_q.rs_data);
    check_val("rt_data",    rt_o,             exp_q.rt_data);
    check_val("imm",        imm_o,            exp_q.imm);
    check_val("shamt",      {27'd0, shamt_o}, {27'd0, exp_q.shamt});
    check_val("rs_addr",    {27'd0, rsa_o},   {27'd0, exp_q.rs_addr});
    check_val("rt_addr",    {27'd0, rta_o},   {27'd0, exp_q.rt_addr});
    check_val("dest_addr",  {27'd0, dst_o},   {27'd0, exp_q.dest});
    check_val("alu_op",     {28'd0, alu_o},   {28'd0, exp_q.alu_op});
    check_val("ctrl_bits",  {27'd0, srci_o, mr_o, mw_o, m2r_o, rw_o},
              {27'd0, exp_q.src_imm, exp_q.mr, exp_q.mw, exp_q.m2r, exp_q.rw});
  endtask

  // One clock: check combinational outputs, advance the model, check the latch.
  task automatic run_cycle();
    logic [31:0] rsv, rtv, tgt;
    logic [4:0]  rs, rt;
    logic        hz, st, jp, is_j, is_jr;
    idex_t       nxt;
    #2;
    rs = instr[25:21];
    rt = instr[20:16];
    rsv = (wb_we && wb_addr == rs && rs != 0) ? wb_data : d_rs;
    rtv = (wb_we && wb_addr == rt && rt != 0) ? wb_data : d_rt;
    hz  = valid && ex_mr && ex_rt != 0 && (ex_rt == rs || (uses_rt(instr) && ex_rt == rt));
    st  = en && (exp_halt || hz);
    is_j  = (instr != 32'hFFFF_FFFF) && (instr[31:26] == 6'd2 || instr[31:26] == 6'd3);
    is_jr = (instr[31:26] == 6'd0) && (instr[5:0] == 6'd8 || instr[5:0] == 6'd9);
    jp  = en && valid && !exp_halt && !st && (is_j || is_jr);
    tgt = is_jr ? rsv : {pc4[31:28], instr[25:0], 2'b00};
    check_val("read_addr_rs", {27'd0, ra_rs}, {27'd0, rs});
    check_val("read_addr_rt", {27'd0, ra_rt}, {27'd0, rt});
    check_val("stall", {31'd0, stall}, {31'd0, st});
    check_val("jump",  {31'd0, jump},  {31'd0, jp});
    if (jp) check_val("jump_target", jtgt, tgt);
    if (!valid || exp_halt || hz || instr == 32'hFFFF_FFFF) nxt = '0;
    else nxt = ref_decode(instr, pc4, rsv, rtv);
    @(posedge clk);
    if (rst) begin
      exp_q    = '0;
      exp_halt = 1'b0;
    end else if (en) begin
      exp_halt = exp_halt || (valid && instr == 32'hFFFF_FFFF && !hz);
      exp_q    = nxt;
    end
    #1;
    check_regs();
  endtask

  task automatic idle();
    rst = 0; en = 1; valid = 1; instr = 32'h0; pc4 = 32'h0040_0004;
    d_rs = 0; d_rt = 0; wb_we = 0; wb_addr = 0; wb_data = 0; ex_mr = 0; ex_rt = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fn_tab [12] = '{6'd0, 6'd2, 6'd3, 6'd8, 6'd9, 6'd33, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42};
    logic [5:0] op_tab [12] = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
    int unsigned k;
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    sh  = 5'($urandom);
    imm = 16'($urandom);
    if ($urandom_range(0, 299) == 0) return 32'hFFFF_FFFF;
    if ($urandom_range(0, 15) == 0) return $urandom;
    k = $urandom_range(0, 23);
    if (k < 12) return {6'd0, rs, rt, rd, sh, fn_tab[k]};
    if (op_tab[k-12] == 6'd2 || op_tab[k-12] == 6'd3) return {op_tab[k-12], 26'($urandom)};
    return {op_tab[k-12], rs, rt, imm};
  endfunction

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    exp_q = '0; exp_halt = 0;

    // Reset holds the latch clear even with a valid ADDU present.
    instr = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    run_cycle();
    check_val("reset_valid", {31'd0, v_o}, 32'd0);
    rst = 0;
    run_cycle();
    check_val("after_reset_valid", {31'd0, v_o}, 32'd1);
    check_val("after_reset_dest", {27'd0, dst_o}, 32'd3);

    // ADDIU $2,$1,-4
    instr = 32'h2422_FFFC; d_rs = 32'd10;
    run_cycle();
    check_val("addiu_rs", rs_o, 32'd10);
    check_val("addiu_imm", imm_o, 32'hFFFF_FFFC);
    check_val("addiu_dest", {27'd0, dst_o}, 32'd2);
    check_val("addiu_src_rw", {30'd0, srci_o, rw_o}, 32'd3);

    // WB bypass on both operands
    instr = {6'd0, 5'd1, 5'd1, 5'd3, 5'd0, 6'h21};
    d_rs = 32'h7; d_rt = 32'h7; wb_we = 1; wb_addr = 5'd1; wb_data = 32'h55;
    run_cycle();
    check_val("bypass_rs", rs_o, 32'h55);
    check_val("bypass_rt", rt_o, 32'h55);
    wb_we = 0;

    // Load-use stall then issue
    instr = {6'd0, 5'd4, 5'd0, 5'd5, 5'd0, 6'h21}; ex_mr = 1; ex_rt = 5'd4;
    #1 check_val("loaduse_stall", {31'd0, stall}, 32'd1);
    run_cycle();
    check_val("loaduse_bubble", {31'd0, v_o}, 32'd0);
    ex_mr = 0;
    run_cycle();
    check_val("loaduse_issue", {31'd0, v_o}, 32'd1);
    check_val("loaduse_dest", {27'd0, dst_o}, 32'd5);

    // JAL
    instr = 32'h0C00_0010; pc4 = 32'h0040_0008;
    #1 check_val("jal_jump", {31'd0, jump}, 32'd1);
    check_val("jal_target", jtgt, 32'h0000_0040);
    run_cycle();
    check_val("jal_dest", {27'd0, dst_o}, 32'd31);
    check_val("jal_link", rs_o, 32'h0040_0008);

    // HALT is sticky until reset
    instr = 32'hFFFF_FFFF;
    run_cycle();
    check_val("halt_flag", {31'd0, halted}, 32'd1);
    instr = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    #1 check_val("halt_stall", {31'd0, stall}, 32'd1);
    run_cycle();
    check_val("halt_bubble", {31'd0, v_o}, 32'd0);
    rst = 1;
    run_cycle();
    check_val("halt_cleared", {31'd0, halted}, 32'd0);
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 49) == 0);
      en      = ($urandom_range(0, 9) != 0);
      valid   = ($urandom_range(0, 99) < 85);
      instr   = rand_instr();
      pc4     = $urandom & 32'hFFFF_FFFC;
      d_rs    = $urandom;
      d_rt    = $urandom;
      wb_we   = $urandom_range(0, 1) == 1;
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      ex_mr   = ($urandom_range(0, 9) < 3);
      ex_rt   = 5'($urandom_range(0, 7));
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
